// File: rtl/otter_csr_pkg.sv
// Shared CSR addresses, bit positions and cause codes for the OTTER machine-mode
// CSR file and trap sequencer.
package otter_csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MEIE_BIT     = 11;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

    typedef enum logic [11:0] {
        CSR_MSTATUS = ADDR_MSTATUS,
        CSR_MIE     = ADDR_MIE,
        CSR_MTVEC   = ADDR_MTVEC,
        CSR_MEPC    = ADDR_MEPC,
        CSR_MCAUSE  = ADDR_MCAUSE
    } csr_addr_t;

    // Places a single stored flag at its architectural bit position, all else zero.
    function automatic logic [31:0] flag_at(input int pos, input logic val);
        logic [31:0] r;
        r      = '0;
        r[pos] = val;
        return r;
    endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Commit-stage CSR / trap bus between the pipeline (master) and csr_trap_unit (slave).
interface csr_trap_unit_if;

    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [11:0] csr_addr;
    logic        csr_WE;
    logic [31:0] csr_wd;
    logic        mret_exec;

    logic [31:0] csr_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        intr_taken;

    modport master (
        output commit_valid, commit_pc, csr_addr, csr_WE, csr_wd, mret_exec,
        input  csr_rd, redirect, redirect_pc, intr_taken
    );

    modport slave (
        input  commit_valid, commit_pc, csr_addr, csr_WE, csr_wd, mret_exec,
        output csr_rd, redirect, redirect_pc, intr_taken
    );

endinterface

// File: rtl/intr_sync.sv
// N-flop synchronizer for the asynchronous interrupt level, rising-edge detect and
// a pending latch that holds until the trap sequencer clears it.
module intr_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    input  logic clr,
    output logic pending
);

    logic [STAGES-1:0] sync_q;
    logic              level_d;
    logic              pending_q;
    logic              rise;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], async_in};
            level_d <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~level_d;

    // A fresh edge is visible as pending in the same cycle it is detected, so the
    // sequencer can take it without an extra cycle of latency.
    assign pending = pending_q | rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending & ~clr;
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and external-interrupt / MRET sequencer at the commit
// point of the OTTER pipeline; drives the registered fetch redirect.
module csr_trap_unit
    import otter_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            intr,
    csr_trap_unit_if.slave  bus
);

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic [31:2] mtvec_q;
    logic [31:2] mepc_q;
    logic [31:0] mcause_q;

    logic        redirect_q;
    logic        intr_taken_q;
    logic [31:0] redirect_pc_q;

    logic        pending;
    logic        take;
    logic        do_mret;
    logic        do_write;
    logic [31:0] csr_rd_c;

    intr_sync #(
        .STAGES (SYNC_STAGES)
    ) u_intr_sync (
        .clk      (CLK),
        .rst_n    (RST_N),
        .async_in (intr),
        .clr      (take),
        .pending  (pending)
    );

    // The redirect cycle is always a flushed bubble; the guard keeps a stray
    // commit_valid there from starting a second trap entry.
    assign take     = pending & mstatus_mie & mie_meie & bus.commit_valid & ~redirect_q;
    assign do_mret  = bus.commit_valid & bus.mret_exec & ~take;
    assign do_write = bus.commit_valid & bus.csr_WE & ~take & ~do_mret;

    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        csr_rd_c = '0;
        case (bus.csr_addr)
            CSR_MSTATUS: csr_rd_c = flag_at(MSTATUS_MIE_BIT, mstatus_mie)
                                  | flag_at(MSTATUS_MPIE_BIT, mstatus_mpie);
            CSR_MIE:     csr_rd_c = flag_at(MIE_MEIE_BIT, mie_meie);
            CSR_MTVEC:   csr_rd_c = {mtvec_q, 2'b00};
            CSR_MEPC:    csr_rd_c = {mepc_q, 2'b00};
            CSR_MCAUSE:  csr_rd_c = mcause_q;
            default:     csr_rd_c = '0;
        endcase
    end

    // Priority: interrupt entry, then MRET, then an ordinary CSR write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec_q      <= MTVEC_RST[31:2];
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else if (take) begin
            mepc_q       <= bus.commit_pc[31:2];
            mcause_q     <= MCAUSE_MEI;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (do_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (do_write) begin
            case (bus.csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie  <= bus.csr_wd[MSTATUS_MIE_BIT];
                    mstatus_mpie <= bus.csr_wd[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:    mie_meie <= bus.csr_wd[MIE_MEIE_BIT];
                CSR_MTVEC:  mtvec_q  <= bus.csr_wd[31:2];
                CSR_MEPC:   mepc_q   <= bus.csr_wd[31:2];
                CSR_MCAUSE: mcause_q <= bus.csr_wd;
                default:    ;
            endcase
        end
    end

    // Redirect target is captured from the pre-update mtvec/mepc of the commit cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            redirect_q    <= 1'b0;
            intr_taken_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q   <= take | do_mret;
            intr_taken_q <= take;
            if (take) begin
                redirect_pc_q <= {mtvec_q, 2'b00};
            end else if (do_mret) begin
                redirect_pc_q <= {mepc_q, 2'b00};
            end
        end
    end

    assign bus.csr_rd      = csr_rd_c;
    assign bus.redirect    = redirect_q;
    assign bus.intr_taken  = intr_taken_q;
    assign bus.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: CSR read/write vector table plus
// interrupt-entry, MRET and reset sequences, with a redirect scoreboard.
module tb_csr_trap_unit;

    localparam logic [31:0] MTVEC_RST   = 32'h0000_0080;
    localparam int          SYNC_STAGES = 2;

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        it;
    } redir_t;

    logic CLK;
    logic RST_N;
    logic intr;
    int   cycle;
    int   n_cmp;
    int   n_err;

    vec_t        vecs[$];
    redir_t      redir_q[$];
    logic [31:0] rd_q[$];

    csr_trap_unit_if bus ();

    csr_trap_unit #(
        .MTVEC_RST   (MTVEC_RST),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .intr  (intr),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cycle = 0;
    always @(posedge CLK) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every redirect/intr_taken pulse must match an entry the stimulus predicted.
    always @(negedge CLK) begin
        if (bus.redirect === 1'b1 || bus.intr_taken === 1'b1) begin
            if (redir_q.size() == 0) begin
                check("unexpected_redirect", {30'b0, bus.redirect, bus.intr_taken}, 32'h0);
            end else begin
                redir_t e;
                e = redir_q.pop_front();
                check("redirect_cycle", cycle, e.cyc);
                check("redirect", {31'b0, bus.redirect}, 32'h1);
                check("redirect_pc", bus.redirect_pc, e.pc);
                check("intr_taken", {31'b0, bus.intr_taken}, {31'b0, e.it});
            end
        end
    end

    task automatic step(input logic v, input logic we, input logic mr,
                        input logic [11:0] a, input logic [31:0] wd, input logic [31:0] pc);
        @(posedge CLK);
        #2;
        bus.commit_valid = v;
        bus.csr_WE       = we;
        bus.mret_exec    = mr;
        bus.csr_addr     = a;
        bus.csr_wd       = wd;
        bus.commit_pc    = pc;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0);
    endtask

    task automatic read_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        step(1'b0, 1'b0, 1'b0, a, 32'h0, 32'h0);
        rd_q.push_back(exp);
        #1;
        check(name, bus.csr_rd, rd_q.pop_front());
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] wd, input logic [31:0] pc);
        step(1'b1, 1'b1, 1'b0, a, wd, pc);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (redir_q.size() == 0) break;
            @(negedge CLK);
            #1;
        end
        if (redir_q.size() != 0) begin
            check("redirect_timeout", redir_q.size(), 32'h0);
            redir_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST_N = 1'b0;
        intr  = 1'b0;
        bus.commit_valid = 1'b0;
        bus.csr_WE       = 1'b0;
        bus.mret_exec    = 1'b0;
        bus.csr_addr     = 12'h000;
        bus.csr_wd       = 32'h0;
        bus.commit_pc    = 32'h0;

        vecs.push_back('{addr: 12'h300, we: 1'b0, wd: 32'h0,         exp_rd: 32'h0});
        vecs.push_back('{addr: 12'h304, we: 1'b0, wd: 32'h0,         exp_rd: 32'h0});
        vecs.push_back('{addr: 12'h305, we: 1'b0, wd: 32'h0,         exp_rd: MTVEC_RST});
        vecs.push_back('{addr: 12'h341, we: 1'b0, wd: 32'h0,         exp_rd: 32'h0});
        vecs.push_back('{addr: 12'h342, we: 1'b0, wd: 32'h0,         exp_rd: 32'h0});
        vecs.push_back('{addr: 12'h123, we: 1'b0, wd: 32'h0,         exp_rd: 32'h0});
        vecs.push_back('{addr: 12'h300, we: 1'b1, wd: 32'hFFFF_FFFF, exp_rd: 32'h0});
        vecs.push_back('{addr: 12'h300, we: 1'b0, wd: 32'h0,         exp_rd: 32'h0000_0088});
        vecs.push_back('{addr: 12'h305, we: 1'b1, wd: 32'h0000_0103, exp_rd: MTVEC_RST});
        vecs.push_back('{addr: 12'h305, we: 1'b0, wd: 32'h0,         exp_rd: 32'h0000_0100});
        vecs.push_back('{addr: 12'h304, we: 1'b1, wd: 32'hFFFF_FFFF, exp_rd: 32'h0});
        vecs.push_back('{addr: 12'h304, we: 1'b0, wd: 32'h0,         exp_rd: 32'h0000_0800});
        vecs.push_back('{addr: 12'h341, we: 1'b1, wd: 32'h0000_0047, exp_rd: 32'h0});
        vecs.push_back('{addr: 12'h341, we: 1'b0, wd: 32'h0,         exp_rd: 32'h0000_0044});
        vecs.push_back('{addr: 12'h342, we: 1'b1, wd: 32'hDEAD_BEEF, exp_rd: 32'h0});
        vecs.push_back('{addr: 12'h342, we: 1'b0, wd: 32'h0,         exp_rd: 32'hDEAD_BEEF});
        vecs.push_back('{addr: 12'h123, we: 1'b1, wd: 32'h0000_0055, exp_rd: 32'h0});
        vecs.push_back('{addr: 12'h123, we: 1'b0, wd: 32'h0,         exp_rd: 32'h0});
        vecs.push_back('{addr: 12'h300, we: 1'b1, wd: 32'h0,         exp_rd: 32'h0000_0088});
        vecs.push_back('{addr: 12'h300, we: 1'b0, wd: 32'h0,         exp_rd: 32'h0});

        #12;
        check("rst_redirect", {31'b0, bus.redirect}, 32'h0);
        check("rst_intr_taken", {31'b0, bus.intr_taken}, 32'h0);
        check("rst_redirect_pc", bus.redirect_pc, 32'h0);
        RST_N = 1'b1;

        // CSR read/write table: csr_rd must show the value before this commit's write.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].we, 1'b0, vecs[i].addr, vecs[i].wd, 32'h0000_0100);
            rd_q.push_back(vecs[i].exp_rd);
            #1;
            check($sformatf("vec%0d_rd", i), bus.csr_rd, rd_q.pop_front());
        end

        // Interrupt entry with a continuously committing instruction at 0x40.
        csr_write(12'h305, 32'h0000_0200, 32'h10);
        csr_write(12'h300, 32'h0000_0008, 32'h14);
        csr_write(12'h304, 32'h0000_0800, 32'h18);
        step(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0000_0040);
        intr = 1'b1;
        redir_q.push_back('{cyc: cycle + SYNC_STAGES + 1, pc: 32'h0000_0200, it: 1'b1});
        wait_drain(12);
        idle();
        intr = 1'b0;
        read_chk("entry_mepc", 12'h341, 32'h0000_0040);
        read_chk("entry_mcause", 12'h342, 32'h8000_000B);
        read_chk("entry_mstatus", 12'h300, 32'h0000_0080);

        // MRET returns to mepc and restores MIE from MPIE.
        step(1'b1, 1'b0, 1'b1, 12'h000, 32'h0, 32'h0000_0060);
        redir_q.push_back('{cyc: cycle + 1, pc: 32'h0000_0040, it: 1'b0});
        idle();
        wait_drain(6);
        read_chk("mret_mstatus", 12'h300, 32'h0000_0088);

        // Pending interrupt waits through bubbles, then wins over a coincident mepc write.
        intr = 1'b1;
        repeat (5) idle();
        csr_write(12'h341, 32'h0000_1234, 32'h0000_0080);
        redir_q.push_back('{cyc: cycle + 1, pc: 32'h0000_0200, it: 1'b1});
        idle();
        wait_drain(6);
        intr = 1'b0;
        read_chk("squash_mepc", 12'h341, 32'h0000_0080);
        read_chk("squash_mcause", 12'h342, 32'h8000_000B);
        read_chk("squash_mstatus", 12'h300, 32'h0000_0080);

        // One-cycle pulse while MIE=0 stays pending; taken at the first commit after enabling.
        idle();
        intr = 1'b1;
        idle();
        intr = 1'b0;
        repeat (4) step(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0000_0088);
        csr_write(12'h300, 32'h0000_0008, 32'h0000_0090);
        idle();
        step(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0000_0094);
        redir_q.push_back('{cyc: cycle + 1, pc: 32'h0000_0200, it: 1'b1});
        idle();
        wait_drain(6);
        read_chk("late_enable_mepc", 12'h341, 32'h0000_0094);

        // Pend an interrupt, then reset: pending and outputs clear asynchronously.
        csr_write(12'h300, 32'h0000_0008, 32'h0000_00A0);
        idle();
        intr = 1'b1;
        repeat (4) idle();
        intr = 1'b0;
        repeat (3) idle();
        #1;
        RST_N = 1'b0;
        bus.csr_addr = 12'h300;
        #1;
        check("async_rst_redirect", {31'b0, bus.redirect}, 32'h0);
        check("async_rst_redirect_pc", bus.redirect_pc, 32'h0);
        check("async_rst_mstatus", bus.csr_rd, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        read_chk("post_rst_mtvec", 12'h305, MTVEC_RST);
        csr_write(12'h300, 32'h0000_0008, 32'h0000_00B0);
        csr_write(12'h304, 32'h0000_0800, 32'h0000_00B4);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0000_00C0);
            #1;
            check($sformatf("post_rst_no_redirect%0d", i), {31'b0, bus.redirect}, 32'h0);
        end
        repeat (2) idle();
        check("scoreboard_empty", redir_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR register file and interrupt/trap sequencer for the OTTER 5-stage pipeline.
- Sits at the writeback/commit point and acts on the decoder's csr_WE and mret_exec controls.
- Provides CSR read data for the register-file write mux.
- Decides interrupt entry and MRET return, and drives the PC redirect (target plus flush pulse) to fetch.

Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- SYNC_STAGES, 2, flop count of the external interrupt synchronizer (min 2).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- intr  in  1  external interrupt request, asynchronous level.
- commit_valid  in  1  instruction in commit stage is valid and not stalled this cycle.
- commit_pc  in  32  PC of the committing instruction.
- csr_addr  in  12  CSR address (instr[31:20]).
- csr_WE  in  1  CSR write enable from decoder, qualified by commit_valid.
- csr_wd  in  32  CSR write data (ALU result).
- mret_exec  in  1  MRET executing, qualified by commit_valid.
- csr_rd  out  32  combinational read of addressed CSR (pre-write value).
- redirect  out  1  one-cycle pulse: flush pipeline, load redirect_pc.
- redirect_pc  out  32  trap vector or mepc.
- intr_taken  out  1  one-cycle pulse on interrupt entry.

Behaviour:
- Reset values: mstatus=0, mie=0, mepc=0, mcause=0, mtvec=MTVEC_RST, pending=0, synchronizer=0. Outputs redirect=0, intr_taken=0, redirect_pc=0.
- CSRs and addresses:
  - mstatus 0x300: only bit3 MIE and bit7 MPIE are stored; all other bits read 0.
  - mie 0x304: only bit11 MEIE is stored.
  - mtvec 0x305: bits[1:0] read 0 (direct mode).
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342: full 32 bits, writable.
  - Unimplemented addresses read 0; writes to them are ignored.
- CSR write: when commit_valid & csr_WE and no interrupt is taken that cycle, the addressed CSR gets csr_wd, masked as above, at the next edge. csr_rd returns the old value in the same cycle, as required by CSRRW/RS/RC.
- Interrupt input:
  - intr passes through SYNC_STAGES flops.
  - A rising edge of the synchronized level sets pending.
  - pending stays set until the interrupt is taken; further edges while pending are absorbed.
- Take condition: pending & mstatus.MIE & mie.MEIE & commit_valid. When it holds:
  - The committing instruction is squashed: its csr_WE and mret_exec are ignored.
  - mepc <= commit_pc; mcause <= 32'h8000_000B.
  - MPIE <= MIE; MIE <= 0; pending <= 0.
  - Registered outputs next cycle: redirect=1, intr_taken=1, redirect_pc=mtvec.
- MRET, when commit_valid & mret_exec and no take: MIE <= MPIE, MPIE <= 1. Next cycle: redirect=1, redirect_pc=mepc (value before any update that cycle).
- Latency: redirect is asserted exactly 1 cycle after the triggering commit. The pulse lasts exactly one cycle.
- No take when commit_valid=0: pending waits, so bubbles and stalls never cause entry.
- The cycle in which redirect is high has commit_valid=0, because fetch flushes the pipeline; a take in that cycle is therefore impossible. The RTL guards this explicitly anyway.
- A CSR write that clears MIE or MEIE blocks a take only from the next cycle onward.
- Reset mid-operation clears pending and any in-flight redirect immediately, asynchronously.
- Priority in the same cycle: interrupt take > MRET > CSR write.

Decomposition:
- Shared package otter_csr_pkg holds:
  - CSR address localparams.
  - MSTATUS_MIE_BIT=3, MSTATUS_MPIE_BIT=7, MIE_MEIE_BIT=11.
  - MCAUSE_MEI=32'h8000_000B.
  - A typedef enum for csr_addr_t.
- One sub-module: intr_sync, an N-stage synchronizer plus rising-edge detector with pending latch and a clear input.

Test Plan:
- Reset then read all five addresses -> csr_rd = 0, 0, 0, 0, MTVEC_RST; redirect=0.
- Write 0x300=0xFFFF_FFFF, 0x305=0x0000_0103 -> read back 0x0000_0088 and 0x0000_0100.
- MIE=1, MEIE=1, mtvec=0x200; raise intr; commit_pc=0x40 committing -> SYNC_STAGES+1 cycles later redirect=1, redirect_pc=0x200, mepc=0x40, mcause=0x8000_000B, MIE=0, MPIE=1.
- Then MRET commit with mepc=0x40 -> next cycle redirect_pc=0x40, MIE=1, MPIE=1.
- Pending interrupt coincident with a committing csr_WE to 0x341 with wd=0x1234 -> write suppressed, mepc=commit_pc, interrupt taken.
- intr pulse with MIE=0, then set MIE via CSR write -> interrupt taken on the first valid commit after the write. Next, pend an interrupt and assert RST_N low -> no redirect after reset is released.
